// File: rtl/clock_seg_scan_pkg.sv
// Shared constants for the multiplexed 6-digit clock display: segment codes,
// digit slot indices and the separator (decimal point) mask.
package clock_seg_scan_pkg;

   typedef logic [3:0] bcd_t;
   typedef logic [2:0] dig_idx_t;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [6:0] SEG7_DASH = 7'h3F;
   localparam logic [5:0] AN_OFF    = 6'h3F;

   localparam dig_idx_t DIG_SEC_ONE  = 3'd0;
   localparam dig_idx_t DIG_SEC_TEN  = 3'd1;
   localparam dig_idx_t DIG_MIN_ONE  = 3'd2;
   localparam dig_idx_t DIG_MIN_TEN  = 3'd3;
   localparam dig_idx_t DIG_HOUR_ONE = 3'd4;
   localparam dig_idx_t DIG_HOUR_TEN = 3'd5;

   // Separators sit after the minutes-ones and hours-ones digits: HH.MM.SS
   localparam logic [5:0] DP_DIGIT_MASK = 6'b010100;

   // Active-low one-hot anode pattern for a digit slot.
   function automatic logic [5:0] an_select(dig_idx_t idx);
      return ~(6'd1 << idx);
   endfunction

endpackage

// File: rtl/clock_seg_scan_bcd_to_seg7.sv
// Combinational BCD to active-low gfedcba pattern; non-decimal codes show a dash.
module bcd_to_seg7
   import clock_seg_scan_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      case (bcd)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = SEG7_DASH;
      endcase
   end

endmodule

// File: rtl/clock_seg_scan.sv
// Multiplexed 6-digit common-anode display driver with frame snapshot, ghost blanking,
// leading-zero blanking and HH.MM.SS separators. Define CLOCK_SEG_BLINK_EN for set-field blink.
module clock_seg_scan
   import clock_seg_scan_pkg::*;
#(
   parameter int unsigned DIGIT_CYCLES    = 8333,
   parameter int unsigned BLANK_CYCLES    = 16,
   parameter int unsigned LEAD_ZERO_BLANK = 1,
   parameter int unsigned BLINK_CYCLES    = 12500000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] Q_SEC_ONE,
   input  logic [3:0] Q_SEC_TEN,
   input  logic [3:0] Q_MIN_ONE,
   input  logic [3:0] Q_MIN_TEN,
   input  logic [3:0] Q_HOUR_ONE,
   input  logic [3:0] Q_HOUR_TEN,
   input  logic       SET_MODE,
   input  logic       SET_HOUR,
   output logic [7:0] SEG,
   output logic [5:0] AN
);

   localparam int PW = $clog2(DIGIT_CYCLES);

   logic [PW-1:0]   presc_q, presc_d;
   dig_idx_t        idx_q, idx_d;
   bcd_t [5:0]      frame_q, frame_d, digits_in;
   logic [7:0]      seg_q, seg_d;
   logic [5:0]      an_q, an_d;
   logic            presc_wrap, field_blink, digit_blank;
   bcd_t            cur_digit;
   logic [6:0]      cur_seg7;

   assign digits_in  = {Q_HOUR_TEN, Q_HOUR_ONE, Q_MIN_TEN, Q_MIN_ONE, Q_SEC_TEN, Q_SEC_ONE};
   assign presc_wrap = (32'(presc_q) == DIGIT_CYCLES - 1);

   always_comb begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
      frame_d = frame_q;
      if (presc_wrap) begin
         presc_d = '0;
         if (idx_q == DIG_HOUR_TEN) begin
            idx_d   = DIG_SEC_ONE;
            // Capture the whole time at frame start so a frame never mixes two times.
            frame_d = digits_in;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end
   end

`ifdef CLOCK_SEG_BLINK_EN
   localparam int BW = $clog2(BLINK_CYCLES);

   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_q, blink_d;

   always_comb begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      blink_d     = blink_q;
      if (!SET_MODE) begin
         blink_cnt_d = '0;
         blink_d     = 1'b0;
      end else if (32'(blink_cnt_q) == BLINK_CYCLES - 1) begin
         blink_cnt_d = '0;
         blink_d     = ~blink_q;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
      end
   end

   always_comb begin
      field_blink = 1'b0;
      if (SET_MODE && blink_q) begin
         if (SET_HOUR) field_blink = (idx_q == DIG_HOUR_ONE) || (idx_q == DIG_HOUR_TEN);
         else          field_blink = (idx_q == DIG_MIN_ONE) || (idx_q == DIG_MIN_TEN);
      end
   end
`else
   logic unused_blink_cfg;
   assign unused_blink_cfg = ^{SET_MODE, SET_HOUR, 32'(BLINK_CYCLES)};
   assign field_blink      = 1'b0;
`endif

   assign cur_digit = frame_q[idx_q];

   bcd_to_seg7 u_dec (
      .bcd (cur_digit),
      .seg (cur_seg7)
   );

   always_comb begin
      digit_blank = field_blink;
      if (LEAD_ZERO_BLANK != 0 && idx_q == DIG_HOUR_TEN && cur_digit == 4'd0) begin
         digit_blank = 1'b1;
      end
      if (32'(presc_q) < BLANK_CYCLES) begin
         an_d  = AN_OFF;
         seg_d = SEG_BLANK;
      end else begin
         // A blanked digit keeps its anode driven; only the segments go dark.
         an_d  = an_select(idx_q);
         seg_d = digit_blank ? SEG_BLANK : {~DP_DIGIT_MASK[idx_q], cur_seg7};
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         presc_q <= '0;
         idx_q   <= DIG_SEC_ONE;
         frame_q <= '0;
         seg_q   <= SEG_BLANK;
         an_q    <= AN_OFF;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign SEG = seg_q;
   assign AN  = an_q;

endmodule

// File: tb/tb_clock_seg_scan.sv
// Directed bench for clock_seg_scan: scan timing, decode, separators, snapshot,
// leading-zero blanking (two instances) and set-field blink.
module tb_clock_seg_scan;

   logic       CLK = 1'b0;
   logic       RST;
   logic [3:0] Q_SEC_ONE, Q_SEC_TEN, Q_MIN_ONE, Q_MIN_TEN, Q_HOUR_ONE, Q_HOUR_TEN;
   logic       SET_MODE, SET_HOUR;
   logic [7:0] SEG, SEG_NLZ;
   logic [5:0] AN, AN_NLZ;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 CLK = ~CLK;

   clock_seg_scan #(
      .DIGIT_CYCLES    (8),
      .BLANK_CYCLES    (2),
      .LEAD_ZERO_BLANK (1),
      .BLINK_CYCLES    (40)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .Q_SEC_ONE  (Q_SEC_ONE),
      .Q_SEC_TEN  (Q_SEC_TEN),
      .Q_MIN_ONE  (Q_MIN_ONE),
      .Q_MIN_TEN  (Q_MIN_TEN),
      .Q_HOUR_ONE (Q_HOUR_ONE),
      .Q_HOUR_TEN (Q_HOUR_TEN),
      .SET_MODE   (SET_MODE),
      .SET_HOUR   (SET_HOUR),
      .SEG        (SEG),
      .AN         (AN)
   );

   clock_seg_scan #(
      .DIGIT_CYCLES    (8),
      .BLANK_CYCLES    (2),
      .LEAD_ZERO_BLANK (0),
      .BLINK_CYCLES    (40)
   ) dut_nlz (
      .CLK        (CLK),
      .RST        (RST),
      .Q_SEC_ONE  (Q_SEC_ONE),
      .Q_SEC_TEN  (Q_SEC_TEN),
      .Q_MIN_ONE  (Q_MIN_ONE),
      .Q_MIN_TEN  (Q_MIN_TEN),
      .Q_HOUR_ONE (Q_HOUR_ONE),
      .Q_HOUR_TEN (Q_HOUR_TEN),
      .SET_MODE   (SET_MODE),
      .SET_HOUR   (SET_HOUR),
      .SEG        (SEG_NLZ),
      .AN         (AN_NLZ)
   );

   task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      tests++;
      assert (observed === expected) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance to 1 time unit after edge k counted from reset release.
   task automatic goto(input int k);
      while (cyc < k) begin
         @(posedge CLK);
         cyc++;
      end
      #1;
   endtask

   initial begin
      RST        = 1'b1;
      SET_MODE   = 1'b0;
      SET_HOUR   = 1'b0;
      Q_SEC_ONE  = 4'd0; Q_SEC_TEN  = 4'd0;
      Q_MIN_ONE  = 4'd0; Q_MIN_TEN  = 4'd0;
      Q_HOUR_ONE = 4'd0; Q_HOUR_TEN = 4'd0;
      #1;
      chk("reset_seg", SEG, 8'hFF);
      chk("reset_an", {2'b00, AN}, 8'h3F);
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      cyc = 0;
      // 12:59:05, seen only from the second frame on
      Q_HOUR_TEN = 4'd1; Q_HOUR_ONE = 4'd2;
      Q_MIN_TEN  = 4'd5; Q_MIN_ONE  = 4'd9;
      Q_SEC_TEN  = 4'd0; Q_SEC_ONE  = 4'd5;

      goto(1);   chk("blank_c1_an", {2'b00, AN}, 8'h3F);
      goto(2);   chk("blank_c2_an", {2'b00, AN}, 8'h3F);
      goto(3);   chk("slot0_an", {2'b00, AN}, 8'h3E);
                 chk("frame0_d0_seg", SEG, 8'hC0);
      goto(8);   chk("slot0_end_an", {2'b00, AN}, 8'h3E);
      goto(9);   chk("slot1_blank_an", {2'b00, AN}, 8'h3F);
                 chk("slot1_blank_seg", SEG, 8'hFF);
      goto(11);  chk("slot1_an", {2'b00, AN}, 8'h3D);
      goto(20);  chk("frame0_d2_an", {2'b00, AN}, 8'h3B);
                 chk("frame0_d2_seg", SEG, 8'h40);
      goto(44);  chk("frame0_d5_an", {2'b00, AN}, 8'h1F);
                 chk("frame0_d5_lzb", SEG, 8'hFF);
                 chk("frame0_d5_nolzb", SEG_NLZ, 8'hC0);

      goto(52);  chk("d0_an", {2'b00, AN}, 8'h3E);
                 chk("d0_seg_5", SEG, 8'h92);
      goto(60);  chk("d1_an", {2'b00, AN}, 8'h3D);
                 chk("d1_seg_0", SEG, 8'hC0);
      goto(68);  chk("d2_an", {2'b00, AN}, 8'h3B);
                 chk("d2_seg_9dp", SEG, 8'h10);
      goto(76);  chk("d3_an", {2'b00, AN}, 8'h37);
                 chk("d3_seg_5", SEG, 8'h92);
      goto(84);  chk("d4_an", {2'b00, AN}, 8'h2F);
                 chk("d4_seg_2dp", SEG, 8'h24);
      goto(92);  chk("d5_an", {2'b00, AN}, 8'h1F);
                 chk("d5_seg_1", SEG, 8'hF9);

      // Next frame: 01:C9:03
      Q_SEC_ONE = 4'd3; Q_HOUR_TEN = 4'd0; Q_HOUR_ONE = 4'd1; Q_MIN_TEN = 4'hC;
      goto(100); chk("snap_d0_3", SEG, 8'hB0);
      goto(116);
      Q_SEC_ONE = 4'd4; Q_HOUR_ONE = 4'd7;
      goto(124); chk("dash_an", {2'b00, AN}, 8'h37);
                 chk("dash_seg", SEG, 8'hBF);
      goto(132); chk("snap_d4_held", SEG, 8'h79);
      goto(140); chk("lzb_an", {2'b00, AN}, 8'h1F);
                 chk("lzb_seg", SEG, 8'hFF);
                 chk("nolzb_seg", SEG_NLZ, 8'hC0);
      goto(148); chk("snap_d0_4", SEG, 8'h99);

      // Asynchronous reset in the middle of a lit slot
      #2;
      RST = 1'b1;
      #1;
      chk("async_rst_seg", SEG, 8'hFF);
      chk("async_rst_an", {2'b00, AN}, 8'h3F);
      repeat (2) @(posedge CLK);
      #1;
      RST      = 1'b0;
      cyc      = 0;
      SET_MODE = 1'b1;
      SET_HOUR = 1'b0;

      goto(20);  chk("set_f0_d2", SEG, 8'h40);
      goto(52);  chk("set_d0_steady", SEG, 8'h99);
      goto(60);  chk("set_d1_steady", SEG, 8'hC0);
`ifdef CLOCK_SEG_BLINK_EN
      goto(68);  chk("blink_d2_off", SEG, 8'hFF);
                 chk("blink_d2_an", {2'b00, AN}, 8'h3B);
      goto(76);  chk("blink_d3_off", SEG, 8'hFF);
`else
      goto(68);  chk("noblink_d2", SEG, 8'h10);
                 chk("noblink_d2_an", {2'b00, AN}, 8'h3B);
      goto(76);  chk("noblink_d3", SEG, 8'hBF);
`endif
      goto(84);  chk("set_d4_steady", SEG, 8'h78);
      goto(116); chk("blink_d2_on", SEG, 8'h10);
      goto(117);
      SET_MODE = 1'b0;
      goto(124); chk("setoff_d3", SEG, 8'hBF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
